mgr_wu_cntl: RTL and testbench
==============================

MGR_WU_CNTL -- requirements
Module: mgr_wu_cntl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): ADDR_W, 10, WU memory address width.
REQ-002 The block SHALL have parameter START_ADDR, 0, first work-unit address presented to fetch.
REQ-003 The block SHALL have parameter CREDITS, 4, maximum outstanding WU reads (range 1..15).
REQ-004 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, single clock, all logic rising-edge.
REQ-005 reset_poweron, in, 1: asynchronous, active-high reset.
REQ-006 sys__mgr__ready, in, 1: system permits WU execution.
REQ-007 sys__mgr__thisSynchronized, in, 1: this manager has reached the sync point.
REQ-008 sys__mgr__complete, in, 1: system requests end of execution.
REQ-009 mgr__sys__allSynchronized, out, 1: sync acknowledged.
REQ-010 mcntl__wuf__enable, out, 1: fetch enable.
REQ-011 mcntl__wuf__start_addr, out, ADDR_W: first WU address.
REQ-012 wuf__wum__read, in, 1: fetch issued a WU memory read this cycle.
REQ-013 wum__wud__valid, in, 1: WU memory returned one entry.
REQ-014 wum__wud__icntl, in, 2: instruction delineator (SOM/MOM/EOM/SOM_EOM).
REQ-015 wud__mcntl__ready, in, 1: decode can accept entries.
REQ-016 xxx__wuf__stall, out, 1: stall fetch.
REQ-017 mcntl__sys__instr_count, out, 16: completed instruction count.
REQ-018 mcntl__sys__error, out, 1: sticky credit overflow/underflow flag.

Function
REQ-019 FSM states SHALL be IDLE, SYNC, LOAD, RUN, DRAIN, DONE.
REQ-020 IDLE -> SYNC when sys__mgr__ready=1.
REQ-021 SYNC -> LOAD when sys__mgr__thisSynchronized=1.
REQ-022 LOAD SHALL last exactly 1 cycle, then go to RUN.
REQ-023 RUN -> DRAIN when sys__mgr__complete=1.
REQ-024 DRAIN -> DONE when credit count = 0.
REQ-025 DONE -> IDLE when sys__mgr__ready=0.
REQ-026 In any state other than IDLE, sys__mgr__ready=0 SHALL force the next state to IDLE and clear the credit count. instr_count and error SHALL keep their values.
REQ-027 mgr__sys__allSynchronized SHALL be registered: high the cycle after the FSM is in SYNC with thisSynchronized=1; it SHALL stay high through LOAD, RUN, DRAIN and DONE, and be low in IDLE and SYNC.
REQ-028 mcntl__wuf__start_addr SHALL be a register loaded with START_ADDR on entry to LOAD and held stable while enable=1.
REQ-029 mcntl__wuf__enable SHALL be registered and high only in RUN (first high cycle = first RUN cycle).
REQ-030 Credit count SHALL be 4 bits: +1 on wuf__wum__read, -1 on wum__wud__valid, unchanged when both occur in the same cycle.
REQ-031 xxx__wuf__stall SHALL be combinational and SHALL equal (credit = CREDITS) OR (wud__mcntl__ready = 0) OR (state != RUN).
REQ-032 A read with credit = CREDITS and no same-cycle valid SHALL set error and leave credit saturated.
REQ-033 A valid with credit = 0 and no same-cycle read SHALL set error and leave credit at 0.
REQ-034 instr_count SHALL increment by 1 on each wum__wud__valid with icntl = EOM or SOM_EOM, in RUN or DRAIN only.
REQ-035 instr_count SHALL saturate at 0xFFFF and clear on the IDLE -> SYNC transition.
REQ-036 mcntl__sys__error SHALL clear only on reset.

Reset
REQ-037 Asserting reset_poweron SHALL immediately force: state = IDLE, credit = 0, enable = 0, allSynchronized = 0, start_addr = 0, instr_count = 0, error = 0.
REQ-038 xxx__wuf__stall SHALL read 1 during reset.
REQ-039 Reset asserted mid-RUN SHALL take effect without waiting for outstanding reads to drain.

Structure
REQ-040 A shared package SHALL hold the icntl encoding (SOM=2'b01, MOM=2'b00, EOM=2'b10, SOM_EOM=2'b11), the FSM state encoding and the 16-bit count width.
REQ-041 The credit counter SHALL be one sub-module, mgr_credit_cntr, with inputs inc, dec and clear and outputs count, full, empty and err.
REQ-042 No other sub-modules SHALL be used.

Verification
REQ-043 Normal start: ready=1, thisSynchronized=1 two cycles later -> allSynchronized high 1 cycle later; enable rises 1 cycle after LOAD; start_addr = 0.
REQ-044 Credit full: CREDITS=4, 4 reads with no valid -> stall=1 on the cycle credit reaches 4; one valid -> stall=0 the next cycle.
REQ-045 Simultaneous events: read and valid in the same cycle at credit = 4 -> credit stays 4 and error stays 0.
REQ-046 Drain: complete=1 with credit = 3, then 3 valids with icntl = EOM -> DONE, instr_count = 3.
REQ-047 Error cases: valid at credit = 0 -> error = 1, which persists across a ready deassertion.
REQ-048 Reset mid-operation: reset_poweron pulsed in RUN with credit = 2 -> all outputs return to reset values the same cycle, asynchronously.

Source files
------------

// File: rtl/mgr_wu_cntl_pkg.sv
// Shared encodings for the work-unit manager: instruction delineators,
// manager FSM states and the instruction counter width.
package mgr_wu_cntl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ICNTL_MOM     = 2'b00,
        ICNTL_SOM     = 2'b01,
        ICNTL_EOM     = 2'b10,
        ICNTL_SOM_EOM = 2'b11
    } icntl_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } mgr_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mgr_wu_cntl_if.sv
// Bundle of system, fetch, memory and decode signals seen by the WU manager.
// The manager connects through master; the surrounding system through slave.
interface mgr_wu_cntl_if #(
    parameter int ADDR_W = 10
);
    import mgr_wu_cntl_pkg::*;

    logic              sys__mgr__ready;
    logic              sys__mgr__thisSynchronized;
    logic              sys__mgr__complete;
    logic              mgr__sys__allSynchronized;
    logic              mcntl__wuf__enable;
    logic [ADDR_W-1:0] mcntl__wuf__start_addr;
    logic              wuf__wum__read;
    logic              wum__wud__valid;
    logic [1:0]        wum__wud__icntl;
    logic              wud__mcntl__ready;
    logic              xxx__wuf__stall;
    logic [CNT_W-1:0]  mcntl__sys__instr_count;
    logic              mcntl__sys__error;

    modport master (
        input  sys__mgr__ready,
        input  sys__mgr__thisSynchronized,
        input  sys__mgr__complete,
        output mgr__sys__allSynchronized,
        output mcntl__wuf__enable,
        output mcntl__wuf__start_addr,
        input  wuf__wum__read,
        input  wum__wud__valid,
        input  wum__wud__icntl,
        input  wud__mcntl__ready,
        output xxx__wuf__stall,
        output mcntl__sys__instr_count,
        output mcntl__sys__error
    );

    modport slave (
        output sys__mgr__ready,
        output sys__mgr__thisSynchronized,
        output sys__mgr__complete,
        input  mgr__sys__allSynchronized,
        input  mcntl__wuf__enable,
        input  mcntl__wuf__start_addr,
        output wuf__wum__read,
        output wum__wud__valid,
        output wum__wud__icntl,
        output wud__mcntl__ready,
        input  xxx__wuf__stall,
        input  mcntl__sys__instr_count,
        input  mcntl__sys__error
    );

endinterface

// File: rtl/mgr_credit_cntr.sv
// Outstanding-read credit counter. Saturates at CREDITS and 0; err flags an
// attempted overflow or underflow in the current cycle.
module mgr_credit_cntr #(
    parameter int CREDITS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       clear,
    output logic [3:0] count,
    output logic       full,
    output logic       empty,
    output logic       err
);

    localparam logic [3:0] MAX_CREDIT = 4'(CREDITS);

    logic [3:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 4'd0;
        end else if (clear) begin
            count_reg <= 4'd0;
        end else if (inc && !dec && !full) begin
            count_reg <= count_reg + 4'd1;
        end else if (dec && !inc && !empty) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == MAX_CREDIT);
    assign empty = (count_reg == 4'd0);
    // A same-cycle inc/dec pair cancels out and can never be an error.
    assign err   = (inc && !dec && full) || (dec && !inc && empty);

endmodule

// File: rtl/mgr_wu_cntl.sv
// Work-unit manager: sequences sync/load/run/drain with the system, gates
// fetch on read credits and counts completed instructions.
module mgr_wu_cntl
    import mgr_wu_cntl_pkg::*;
#(
    parameter int                ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                CREDITS    = 4
) (
    input  logic             clk,
    input  logic             reset_poweron,
    mgr_wu_cntl_if.master    bus
);

    mgr_state_e        state_reg;
    logic              all_sync_reg;
    logic              enable_reg;
    logic [ADDR_W-1:0] start_addr_reg;
    logic [CNT_W-1:0]  instr_count_reg;
    logic              error_reg;

    logic [3:0]        credit_count;
    logic              credit_full;
    logic              credit_empty;
    logic              credit_err;
    logic              credit_clear;
    logic              instr_done;
    icntl_e            icntl;

    // Dropping ready outside IDLE abandons the work unit, so outstanding credits are forgotten.
    assign credit_clear = (state_reg != ST_IDLE) && !bus.sys__mgr__ready;

    assign icntl      = icntl_e'(bus.wum__wud__icntl);
    assign instr_done = bus.wum__wud__valid
                        && ((icntl == ICNTL_EOM) || (icntl == ICNTL_SOM_EOM))
                        && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));

    mgr_credit_cntr #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk   (clk),
        .rst   (reset_poweron),
        .inc   (bus.wuf__wum__read),
        .dec   (bus.wum__wud__valid),
        .clear (credit_clear),
        .count (credit_count),
        .full  (credit_full),
        .empty (credit_empty),
        .err   (credit_err)
    );

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_reg       <= ST_IDLE;
            all_sync_reg    <= 1'b0;
            enable_reg      <= 1'b0;
            start_addr_reg  <= '0;
            instr_count_reg <= '0;
            error_reg       <= 1'b0;
        end else begin
            if (credit_err) begin
                error_reg <= 1'b1;
            end
            if (instr_done) begin
                instr_count_reg <= sat_inc(instr_count_reg);
            end

            if (credit_clear) begin
                state_reg    <= ST_IDLE;
                all_sync_reg <= 1'b0;
                enable_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (bus.sys__mgr__ready) begin
                            state_reg       <= ST_SYNC;
                            instr_count_reg <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (bus.sys__mgr__thisSynchronized) begin
                            state_reg      <= ST_LOAD;
                            all_sync_reg   <= 1'b1;
                            start_addr_reg <= START_ADDR;
                        end
                    end
                    ST_LOAD: begin
                        state_reg  <= ST_RUN;
                        enable_reg <= 1'b1;
                    end
                    ST_RUN: begin
                        if (bus.sys__mgr__complete) begin
                            state_reg  <= ST_DRAIN;
                            enable_reg <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (credit_empty) begin
                            state_reg <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_DONE;
                    end
                    default: begin
                        state_reg    <= ST_IDLE;
                        all_sync_reg <= 1'b0;
                        enable_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mgr__sys__allSynchronized = all_sync_reg;
    assign bus.mcntl__wuf__enable        = enable_reg;
    assign bus.mcntl__wuf__start_addr    = start_addr_reg;
    assign bus.mcntl__sys__instr_count   = instr_count_reg;
    assign bus.mcntl__sys__error         = error_reg;
    // Reset forces state_reg to IDLE asynchronously, so stall is high throughout reset.
    assign bus.xxx__wuf__stall           = credit_full || !bus.wud__mcntl__ready
                                           || (state_reg != ST_RUN);

endmodule

// File: tb/tb_mgr_wu_cntl.sv
// Randomized bench for mgr_wu_cntl against a phase/credit reference model.
module tb_mgr_wu_cntl;

    localparam int          ADDR_W  = 10;
    localparam logic [9:0]  START   = 10'h155;
    localparam int          CREDITS = 4;

    localparam int P_IDLE = 0, P_SYNC = 1, P_LOAD = 2, P_RUN = 3, P_DRAIN = 4, P_DONE = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mgr_wu_cntl_if #(.ADDR_W(ADDR_W)) bus ();

    mgr_wu_cntl #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (START),
        .CREDITS    (CREDITS)
    ) dut (
        .clk           (clk),
        .reset_poweron (rst),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_phase;
    int m_credit;
    int m_instr;
    int m_addr;
    bit m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = P_IDLE;
        m_credit = 0;
        m_instr  = 0;
        m_addr   = 0;
        m_err    = 1'b0;
    endtask

    function automatic bit model_stall(input bit wready);
        return (m_credit == CREDITS) || !wready || (m_phase != P_RUN);
    endfunction

    task automatic check_outputs();
        check_val("allSync",    32'(bus.mgr__sys__allSynchronized), 32'(m_phase >= P_LOAD));
        check_val("enable",     32'(bus.mcntl__wuf__enable),        32'(m_phase == P_RUN));
        check_val("start_addr", 32'(bus.mcntl__wuf__start_addr),    32'(m_addr));
        check_val("instr",      32'(bus.mcntl__sys__instr_count),   32'(m_instr));
        check_val("error",      32'(bus.mcntl__sys__error),         32'(m_err));
        check_val("stall",      32'(bus.xxx__wuf__stall),           32'(model_stall(bus.wud__mcntl__ready)));
    endtask

    // Applies the behavioural rules for one rising edge using the inputs sampled there.
    task automatic model_update();
        bit rd    = bus.wuf__wum__read;
        bit vl    = bus.wum__wud__valid;
        bit ready = bus.sys__mgr__ready;
        bit eom   = (bus.wum__wud__icntl == 2'b10) || (bus.wum__wud__icntl == 2'b11);
        int nxt   = m_phase;
        int c     = m_credit;

        if (rd && !vl && c == CREDITS) m_err = 1'b1;
        if (vl && !rd && c == 0)       m_err = 1'b1;
        if ((m_phase == P_RUN || m_phase == P_DRAIN) && vl && eom && m_instr < 65535)
            m_instr++;

        c = c + int'(rd) - int'(vl);
        if (c > CREDITS) c = CREDITS;
        if (c < 0)       c = 0;

        if (m_phase != P_IDLE && !ready) begin
            nxt = P_IDLE;
            c   = 0;
        end else begin
            case (m_phase)
                P_IDLE:  if (ready) begin nxt = P_SYNC; m_instr = 0; end
                P_SYNC:  if (bus.sys__mgr__thisSynchronized) begin nxt = P_LOAD; m_addr = int'(START); end
                P_LOAD:  nxt = P_RUN;
                P_RUN:   if (bus.sys__mgr__complete) nxt = P_DRAIN;
                P_DRAIN: if (m_credit == 0) nxt = P_DONE;
                default: nxt = m_phase;
            endcase
        end
        m_phase  = nxt;
        m_credit = c;
    endtask

    task automatic step();
        check_outputs();
        @(posedge clk);
        if (rst) model_reset();
        else     model_update();
        #1;
    endtask

    task automatic drive(input bit ready, input bit ts, input bit comp, input bit rd,
                         input bit vl, input logic [1:0] icntl, input bit wready);
        bus.sys__mgr__ready            = ready;
        bus.sys__mgr__thisSynchronized = ts;
        bus.sys__mgr__complete         = comp;
        bus.wuf__wum__read             = rd;
        bus.wum__wud__valid            = vl;
        bus.wum__wud__icntl            = icntl;
        bus.wud__mcntl__ready          = wready;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 2'b00, 0);
        model_reset();
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal start
        $display("txn: normal start");
        drive(1, 0, 0, 0, 0, 2'b00, 1); step();
        step();
        drive(1, 1, 0, 0, 0, 2'b00, 1); step();
        drive(1, 0, 0, 0, 0, 2'b00, 1); step();
        check_val("start_enable", 32'(bus.mcntl__wuf__enable), 32'd1);

        // Fill credits, then simultaneous read/valid at full
        $display("txn: credit fill");
        repeat (4) begin drive(1, 0, 0, 1, 0, 2'b00, 1); step(); end
        drive(1, 0, 0, 0, 0, 2'b00, 1);
        check_val("full_stall", 32'(bus.xxx__wuf__stall), 32'd1);
        $display("txn: read+valid at full");
        drive(1, 0, 0, 1, 1, 2'b00, 1); step();
        drive(1, 0, 0, 0, 1, 2'b00, 1); step();
        drive(1, 0, 0, 0, 0, 2'b00, 1);
        check_val("unfull_stall", 32'(bus.xxx__wuf__stall), 32'd0);
        step();

        // Drain with three EOM entries
        $display("txn: drain");
        drive(1, 0, 1, 0, 0, 2'b00, 1); step();
        repeat (3) begin drive(1, 0, 0, 0, 1, 2'b10, 1); step(); end
        drive(1, 0, 0, 0, 0, 2'b00, 1); step();
        step();
        check_val("drain_instr", 32'(bus.mcntl__sys__instr_count), 32'd3);

        // Underflow error persists across ready drop
        $display("txn: underflow");
        drive(1, 0, 0, 0, 1, 2'b01, 1); step();
        drive(0, 0, 0, 0, 0, 2'b00, 1); step();
        step();
        check_val("err_persist", 32'(bus.mcntl__sys__error), 32'd1);

        // Async reset in RUN with two outstanding reads
        $display("txn: reset mid-run");
        drive(1, 0, 0, 0, 0, 2'b00, 1); step();
        drive(1, 1, 0, 0, 0, 2'b00, 1); step();
        drive(1, 0, 0, 0, 0, 2'b00, 1); step();
        repeat (2) begin drive(1, 0, 0, 1, 0, 2'b00, 1); step(); end
        drive(1, 0, 0, 0, 0, 2'b00, 1);
        check_outputs();
        #1 rst = 1'b1;
        #1;
        check_val("rst_allSync", 32'(bus.mgr__sys__allSynchronized), 32'd0);
        check_val("rst_enable",  32'(bus.mcntl__wuf__enable),        32'd0);
        check_val("rst_addr",    32'(bus.mcntl__wuf__start_addr),    32'd0);
        check_val("rst_instr",   32'(bus.mcntl__sys__instr_count),   32'd0);
        check_val("rst_error",   32'(bus.mcntl__sys__error),         32'd0);
        check_val("rst_stall",   32'(bus.xxx__wuf__stall),           32'd1);
        model_reset();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 2'b00, 1);
        rst = 1'b0;
        #1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit ready  = ($urandom_range(0, 79) != 0);
            bit ts     = ($urandom_range(0, 2) == 0);
            bit comp   = ($urandom_range(0, 29) == 0);
            bit wready = ($urandom_range(0, 4) != 0);
            bit rd     = (!model_stall(wready) && $urandom_range(0, 1) == 1)
                         || ($urandom_range(0, 99) == 0);
            bit vl     = (m_credit > 0 && $urandom_range(0, 1) == 1)
                         || ($urandom_range(0, 149) == 0);
            logic [1:0] icntl = 2'($urandom_range(0, 3));
            drive(ready, ts, comp, rd, vl, icntl, wready);
            if (vl) $display("txn %0d: entry icntl=%0d phase=%0d credit=%0d", n, icntl, m_phase, m_credit);
            step();
        end
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
